// File: rtl/cluster_sleep_pkg.sv
// rtl/cluster_sleep_pkg.sv - shared types and register map for the cluster sleep controller
package cluster_sleep_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE  = 3'd0,
    ST_REQ     = 3'd1,
    ST_GATED   = 3'd2,
    ST_RELEASE = 3'd3
  } state_t;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_TIMER_CMP = 3'd1;
  localparam logic [2:0] REG_TIMER_CNT = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;

  localparam int CTRL_GATE_EN      = 0;
  localparam int CTRL_TIMER_EN     = 1;
  localparam int STATUS_WOKE_TIMER = 3;
  localparam int STATUS_WOKE_EVENT = 4;

endpackage

// File: rtl/cluster_sleep_regs.sv
// rtl/cluster_sleep_regs.sv - APB decode, control registers and sticky wake-cause flags
module cluster_sleep_regs
  import cluster_sleep_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  reg_idx,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  input  logic [2:0]  state,
  input  logic [31:0] timer_cnt,
  input  logic        set_woke_timer,
  input  logic        set_woke_event,
  output logic        gate_en,
  output logic        timer_en,
  output logic [31:0] timer_cmp
);

  logic wr;
  logic rd;
  logic woke_by_timer;
  logic woke_by_event;
  logic clr_timer;
  logic clr_event;

  assign wr = PSEL & PENABLE & PWRITE;
  assign rd = PSEL & PENABLE & ~PWRITE;
  assign clr_timer = wr && (reg_idx == REG_STATUS) && PWDATA[STATUS_WOKE_TIMER];
  assign clr_event = wr && (reg_idx == REG_STATUS) && PWDATA[STATUS_WOKE_EVENT];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gate_en       <= 1'b0;
      timer_en      <= 1'b0;
      timer_cmp     <= '0;
      woke_by_timer <= 1'b0;
      woke_by_event <= 1'b0;
    end else begin
      if (wr && reg_idx == REG_CTRL) begin
        gate_en  <= PWDATA[CTRL_GATE_EN];
        timer_en <= PWDATA[CTRL_TIMER_EN];
      end
      if (wr && reg_idx == REG_TIMER_CMP) timer_cmp <= PWDATA;
      // a wake cause arriving in the same cycle as its clear survives
      woke_by_timer <= set_woke_timer | (woke_by_timer & ~clr_timer);
      woke_by_event <= set_woke_event | (woke_by_event & ~clr_event);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (reg_idx)
        REG_CTRL:      PRDATA = {30'd0, timer_en, gate_en};
        REG_TIMER_CMP: PRDATA = timer_cmp;
        REG_TIMER_CNT: PRDATA = timer_cnt;
        REG_STATUS:    PRDATA = {27'd0, woke_by_event, woke_by_timer, state};
        default:       PRDATA = '0;
      endcase
    end
  end

endmodule

// File: rtl/cluster_sleep_ctrl.sv
// rtl/cluster_sleep_ctrl.sv - cluster clock-gate sequencer with power-manager handshake and wake timer
module cluster_sleep_ctrl
  import cluster_sleep_pkg::*;
#(
  parameter int NB_CORES       = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int GUARD_CYCLES   = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NB_CORES-1:0]       core_sleeping_i,
  input  logic                      event_pending_i,
  output logic                      pmu_req_o,
  input  logic                      pmu_ack_i,
  output logic                      cluster_clk_en_o,
  output logic                      timer_wake_o
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_t      state;
  logic [7:0]  guard;
  logic [31:0] timer_cnt;
  logic [31:0] timer_cmp;
  logic        gate_en;
  logic        timer_en;
  logic        wake_from_timer;
  logic        all_asleep;
  logic        guard_inc;
  logic        timer_match;
  logic        set_woke_timer;
  logic        set_woke_event;
  logic        unused_addr;

  assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign all_asleep     = &core_sleeping_i;
  assign guard_inc      = (state == ST_ACTIVE) && gate_en && all_asleep && !event_pending_i;
  assign timer_match    = timer_en && (timer_cnt == timer_cmp);
  assign set_woke_timer = (state == ST_GATED) && timer_match;
  assign set_woke_event = (state == ST_GATED) && event_pending_i;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state           <= ST_ACTIVE;
      guard           <= '0;
      timer_cnt       <= '0;
      wake_from_timer <= 1'b0;
      timer_wake_o    <= 1'b0;
    end else begin
      timer_wake_o <= 1'b0;
      guard        <= '0;
      case (state)
        ST_ACTIVE: begin
          if (guard_inc) begin
            if (guard == GUARD_LAST) state <= ST_REQ;
            else                     guard <= guard + 8'd1;
          end
        end
        ST_REQ: begin
          // an abort never produces a timer wake pulse
          if (event_pending_i || !all_asleep || !gate_en) begin
            state           <= ST_RELEASE;
            wake_from_timer <= 1'b0;
          end else if (pmu_ack_i) begin
            state     <= ST_GATED;
            timer_cnt <= '0;
          end
        end
        ST_GATED: begin
          if (event_pending_i || timer_match) begin
            state           <= ST_RELEASE;
            wake_from_timer <= timer_match;
          end else if (timer_en) begin
            timer_cnt <= timer_cnt + 32'd1;
          end
        end
        ST_RELEASE: begin
          if (!pmu_ack_i) begin
            state        <= ST_ACTIVE;
            timer_wake_o <= wake_from_timer;
          end
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

  assign pmu_req_o        = (state == ST_REQ) || (state == ST_GATED);
  assign cluster_clk_en_o = !((state == ST_GATED) || (state == ST_RELEASE));
  assign PREADY           = 1'b1;
  assign PSLVERR          = 1'b0;

  cluster_sleep_regs u_regs (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .reg_idx        (PADDR[4:2]),
    .PWDATA         (PWDATA),
    .PWRITE         (PWRITE),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PRDATA         (PRDATA),
    .state          (state),
    .timer_cnt      (timer_cnt),
    .set_woke_timer (set_woke_timer),
    .set_woke_event (set_woke_event),
    .gate_en        (gate_en),
    .timer_en       (timer_en),
    .timer_cmp      (timer_cmp)
  );

endmodule
